// File: rtl/mwc_pkg.sv
// Shared types for the data-memory write checker: FSM states and failure codes.
package mwc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_EMPTY    = 2'd3
  } fail_code_t;

endpackage

// File: rtl/mwc_exp_table.sv
// Ordered table of expected (address, data) writes: push at count, async read at rd_idx.
module mwc_exp_table #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [CNT_W-1:0]  rd_idx_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W+DATA_W-1:0] rd_entry;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     push;

  assign full_o  = (count_q == DEPTH_C);
  assign push    = we_i && !full_o && !clr_i;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (push) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; count_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[count_q[IDX_W-1:0]] <= {wr_addr_i, wr_data_i};
    end
  end

  // Once every entry has matched, ptr sits at DEPTH; read zero rather than wrap.
  always_comb begin
    rd_entry = '0;
    if (rd_idx_i < DEPTH_C) begin
      rd_entry = mem_q[rd_idx_i[IDX_W-1:0]];
    end
  end

  assign {rd_addr_o, rd_data_o} = rd_entry;

endmodule

// File: rtl/mem_write_checker.sv
// Self-checking monitor for a core's data-memory write port with sticky PASS/FAIL verdict.
// Optional RUN-state cycle budget is enabled by defining MWC_TIMEOUT_EN.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int              ADDR_W  = 32,
  parameter int              DATA_W  = 32,
  parameter int              DEPTH   = 8,
  parameter logic [ADDR_W-1:0] IGN_LO = 80,
  parameter logic [ADDR_W-1:0] IGN_HI = 80,
  parameter int unsigned     TIMEOUT = 1024,
  localparam int             CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              exp_we,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  state_t            state_q, state_d;
  fail_code_t        fc_q, fc_d;
  logic [CNT_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic              tab_clr, tab_we, tab_full;
  logic [CNT_W-1:0]  tab_count;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic              hit, in_win, last, timed_out;

  mwc_exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (tab_clr),
    .we_i      (tab_we),
    .wr_addr_i (exp_addr),
    .wr_data_i (exp_data),
    .rd_idx_i  (ptr_q),
    .rd_addr_o (cur_addr),
    .rd_data_o (cur_data),
    .count_o   (tab_count),
    .full_o    (tab_full)
  );

  assign hit    = (dataadr == cur_addr) && (writedata == cur_data);
  assign in_win = (IGN_LO <= IGN_HI) && (dataadr >= IGN_LO) && (dataadr <= IGN_HI);
  assign last   = ((ptr_q + CNT_W'(1)) == tab_count);

`ifdef MWC_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  logic [31:0] cyc_q, cyc_d;

  // Held at zero outside RUN, so every entry into RUN starts a fresh budget.
  always_comb begin
    cyc_d = cyc_q;
    if (clear || state_q != RUN) begin
      cyc_d = '0;
    end else if (cyc_q != '1) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign timed_out = (cyc_q >= TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
`endif

  // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    ptr_d   = ptr_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    tab_we  = 1'b0;
    tab_clr = 1'b0;
    if (clear) begin
      state_d = IDLE;
      fc_d    = FC_NONE;
      ptr_d   = '0;
      faddr_d = '0;
      fdata_d = '0;
      tab_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tab_we = exp_we && !tab_full;
          if (start) begin
            if (tab_count == '0 && !exp_we) begin
              state_d = FAIL;
              fc_d    = FC_EMPTY;
            end else begin
              state_d = RUN;
              ptr_d   = '0;
            end
          end
        end
        RUN: begin
          // Written so an unknown compare falls through to the mismatch branch.
          if (memwrite) begin
            if (hit) begin
              ptr_d = ptr_q + CNT_W'(1);
              if (last) state_d = PASS;
            end else if (in_win) begin
              state_d = RUN;
            end else begin
              state_d = FAIL;
              fc_d    = FC_MISMATCH;
              faddr_d = dataadr;
              fdata_d = writedata;
            end
          end
          if (timed_out && state_d == RUN && ptr_d == ptr_q) begin
            state_d = FAIL;
            fc_d    = FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fc_q    <= FC_NONE;
      ptr_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      ptr_q   <= ptr_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == PASS) || (state_q == FAIL);
  assign pass      = (state_q == PASS);
  assign fail_code = fc_q;
  assign match_cnt = ptr_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus random sessions against a queue-based model.
module tb_mem_write_checker;

  localparam int          DEPTH   = 8;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] IGN_LO  = 32'd80;
  localparam logic [31:0] IGN_HI  = 32'd80;

  logic        clk = 1'b0;
  logic        reset, clear, exp_we, start, memwrite;
  logic [31:0] exp_addr, exp_data, dataadr, writedata;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [3:0]  match_cnt;
  logic [31:0] fail_addr, fail_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: verdict 0 idle, 1 running, 2 passed, 3 failed.
  logic [63:0] m_q[$];
  int          m_st, m_code, m_nmatch, m_runcyc;
  logic [31:0] m_faddr, m_fdata;

  always #5 clk = ~clk;

  mem_write_checker #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .IGN_LO (IGN_LO),
    .IGN_HI (IGN_HI),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .exp_we    (exp_we),
    .exp_addr  (exp_addr),
    .exp_data  (exp_data),
    .start     (start),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_code (fail_code),
    .match_cnt (match_cnt),
    .fail_addr (fail_addr),
    .fail_data (fail_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_st     = 0;
    m_code   = 0;
    m_nmatch = 0;
    m_runcyc = 0;
    m_faddr  = '0;
    m_fdata  = '0;
  endtask

  task automatic model_step();
    bit matched;
    matched = 1'b0;
    if (clear) begin
      model_reset();
    end else if (m_st == 0) begin
      if (exp_we && m_q.size() < DEPTH) m_q.push_back({exp_addr, exp_data});
      if (start) begin
        if (m_q.size() == 0) begin
          m_st   = 3;
          m_code = 3;
        end else begin
          m_st     = 1;
          m_runcyc = 0;
        end
      end
    end else if (m_st == 1) begin
      m_runcyc++;
      if (memwrite) begin
        if (m_nmatch < m_q.size() && {dataadr, writedata} == m_q[m_nmatch]) begin
          matched = 1'b1;
          m_nmatch++;
          if (m_nmatch == m_q.size()) m_st = 2;
        end else if (!(dataadr >= IGN_LO && dataadr <= IGN_HI)) begin
          m_st    = 3;
          m_code  = 1;
          m_faddr = dataadr;
          m_fdata = writedata;
        end
      end
`ifdef MWC_TIMEOUT_EN
      if (m_st == 1 && !matched && m_runcyc >= TIMEOUT) begin
        m_st   = 3;
        m_code = 2;
      end
`else
      if (matched && m_runcyc < 0) m_st = 3;
`endif
    end
  endtask

  task automatic check_all(input string where);
    check({where, ".busy"},      busy,      m_st == 1);
    check({where, ".done"},      done,      m_st >= 2);
    check({where, ".pass"},      pass,      m_st == 2);
    check({where, ".fail_code"}, fail_code, m_code);
    check({where, ".match_cnt"}, match_cnt, m_nmatch);
    check({where, ".fail_addr"}, fail_addr, m_faddr);
    check({where, ".fail_data"}, fail_data, m_fdata);
  endtask

  // One clock: model follows the same edge, outputs compared 1 ns later, strobes dropped.
  task automatic tick(input string where = "cyc");
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
    check_all(where);
    clear    = 1'b0;
    exp_we   = 1'b0;
    start    = 1'b0;
    memwrite = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_addr = a; exp_data = d;
    tick("push");
  endtask

  task automatic go();
    start = 1'b1;
    tick("start");
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick("store");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick("clear");
  endtask

  function automatic logic [31:0] pick_addr();
    return 32'(76 + 4 * $urandom_range(0, 4));
  endfunction

  initial begin
    int k, r;
    reset = 1'b1; clear = 1'b0; exp_we = 1'b0; start = 1'b0; memwrite = 1'b0;
    exp_addr = '0; exp_data = '0; dataadr = '0; writedata = '0;
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Scratch-window write ignored, then the single expected write passes.
    do_clear();
    push(84, 7); go();
    store(80, 5); store(84, 7);
    check("t1_pass", pass, 1'b1);
    check("t1_code", fail_code, 2'd0);
    check("t1_cnt",  match_cnt, 4'd1);

    // Wrong address fails, capture holds, later correct write is ignored.
    do_clear();
    push(84, 7); go();
    store(88, 7);
    check("t2_code", fail_code, 2'd1);
    check("t2_addr", fail_addr, 32'd88);
    check("t2_data", fail_data, 32'd7);
    store(84, 7);
    check("t2_sticky_code", fail_code, 2'd1);
    check("t2_sticky_pass", pass, 1'b0);
    check("t2_sticky_cnt",  match_cnt, 4'd0);

    // Fourth entry pushed on the start cycle is part of the run.
    do_clear();
    push(100, 1); push(104, 2); push(108, 3);
    exp_we = 1'b1; exp_addr = 112; exp_data = 4; start = 1'b1;
    tick("t3_start");
    store(100, 1); store(104, 2); store(108, 3);
    check("t3_not_yet", pass, 1'b0);
    check("t3_busy",    busy, 1'b1);
    store(112, 4);
    check("t3_pass", pass, 1'b1);
    check("t3_cnt",  match_cnt, 4'd4);

    // Empty table.
    do_clear();
    go();
    check("t4_done", done, 1'b1);
    check("t4_code", fail_code, 2'd3);

    // Cycle budget in RUN.
    do_clear();
    push(84, 7); go();
`ifdef MWC_TIMEOUT_EN
    repeat (TIMEOUT - 1) tick("t5_wait");
    check("t5_still_busy", busy, 1'b1);
    tick("t5_expire");
    check("t5_code", fail_code, 2'd2);
`else
    repeat (3 * TIMEOUT) tick("t5_wait");
    check("t5_no_timeout", busy, 1'b1);
`endif

    // Asynchronous reset mid-RUN.
    do_clear();
    push(84, 7); push(88, 1); go();
    store(84, 7);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("t6_async");
    check("t6_busy", busy, 1'b0);
    check("t6_cnt",  match_cnt, 4'd0);
    tick("t6_in_reset");
    reset = 1'b1;

    // Clear after a FAIL, then overfill the table.
    push(1, 1); go(); store(2, 2);
    check("t6_failed", fail_code, 2'd1);
    do_clear();
    check("t6_clr_done", done, 1'b0);
    check("t6_clr_code", fail_code, 2'd0);
    check("t6_clr_addr", fail_addr, 32'd0);
    for (int i = 0; i < 9; i++) push(32'(200 + 4 * i), 32'(i));
    exp_we = 1'b1; exp_addr = 999; exp_data = 9; start = 1'b1;
    tick("t6_full_start");
    for (int i = 0; i < 8; i++) store(32'(200 + 4 * i), 32'(i));
    check("t6_full_pass", pass, 1'b1);
    check("t6_full_cnt",  match_cnt, 4'd8);

    // Random sessions.
    for (int s = 0; s < 60; s++) begin
      do_clear();
      k = $urandom_range(0, 9);
      for (int i = 0; i < k; i++) push(pick_addr(), 32'($urandom_range(0, 3)));
      exp_we = 1'($urandom_range(0, 1)); exp_addr = pick_addr();
      exp_data = 32'($urandom_range(0, 3)); start = 1'b1;
      tick("rnd_start");
      for (int c = 0; c < 25; c++) begin
        r = $urandom_range(0, 19);
        if (r < 8 && m_nmatch < m_q.size()) begin
          memwrite = 1'b1; {dataadr, writedata} = m_q[m_nmatch];
        end else if (r < 11) begin
          memwrite = 1'b1; dataadr = 32'd80; writedata = $urandom;
        end else if (r < 15) begin
          memwrite = 1'b1; dataadr = pick_addr(); writedata = 32'($urandom_range(0, 3));
        end
        if (r == 19) begin
          start = 1'b1; exp_we = 1'b1; exp_addr = pick_addr(); exp_data = 32'd1;
        end
        if ($urandom_range(0, 60) == 0) clear = 1'b1;
        tick("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
